direction_input: RTL and testbench
==================================

# direction_input

Input conditioner for the 2048 tile game. Takes the four raw push-buttons, synchronizes and debounces them, and turns each clean press into a single-cycle, one-hot `direction` pulse on the encoding that `game_logic` decodes. A post-move lockout with a one-entry pending buffer gives the downstream grid update time to finish without losing a quick second press. Sits between the board pins and `game_logic.direction`.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive synchronized cycles a button must hold a new level before it is accepted (5 ms at 50 MHz); legal range is 1 or more.
- `LOCKOUT_CYCLES`, default 50000: cycles after each emitted move during which no new move is emitted; legal range is 1 or more.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `btn_right`  in  1  raw button, active-high, asynchronous to `clk`.
- `btn_left`  in  1  raw button, active-high, asynchronous.
- `btn_up`  in  1  raw button, active-high, asynchronous.
- `btn_down`  in  1  raw button, active-high, asynchronous.
- `direction`  out  4  registered one-hot move pulse:
  - `4'b0001` right, `4'b1000` left, `4'b0100` up, `4'b0010` down.
  - `4'b0000` means no move.
- `busy`  out  1  high while in EMIT or LOCKOUT.

## Operation
- **Per-button pipeline** (four identical copies):
  - Two-flop synchronizer produces level `s`.
  - Stable level `d` and counter `cnt`: `cnt` increments each cycle `s != d` and clears whenever `s == d`.
  - When `s != d` and `cnt == DEBOUNCE_CYCLES-1`, `d` takes `s` and `cnt` clears.
  - Press event = `d & ~d_q`, where `d_q` is `d` delayed one cycle. Releases generate nothing, so there is no auto-repeat.
- **Combining press events:**
  - Exactly one press event in a cycle gives a candidate with that button's one-hot code.
  - Two or more press events in the same cycle are ambiguous and all are discarded.
- **FSM states:** IDLE, EMIT, LOCKOUT.
  - IDLE: a candidate moves the FSM to EMIT and registers `direction` to the candidate code.
  - EMIT (exactly 1 cycle): `direction` holds the code. Next state is LOCKOUT with the lockout counter loaded with 0.
  - LOCKOUT: `direction = 0000`. The counter increments each cycle. On the cycle it equals `LOCKOUT_CYCLES-1`:
    - if `pending` is valid, go to EMIT with the pending code and clear `pending`;
    - otherwise go to IDLE.
- **Pending buffer** (one entry, code plus valid):
  - A candidate arriving during EMIT or LOCKOUT is written to it.
  - A later candidate overwrites it (latest wins).
  - A candidate arriving on the same cycle the buffer is consumed becomes the new pending entry.
- Counter widths: `$clog2(DEBOUNCE_CYCLES+1)` and `$clog2(LOCKOUT_CYCLES+1)` bits. No wrap is possible because both counters clear at their terminal value.

## Timing
- **Reset values:**
  - Synchronizers, `d`, `d_q`, `cnt`, the lockout counter and `pending` are all 0.
  - FSM is in IDLE, `direction = 4'b0000`, `busy = 0`.
- **Press latency:** take edge 0 as the first edge that samples the raw input high (stable). Then `s` is high after edge 1, `d` rises at edge `1+DEBOUNCE_CYCLES`, and `direction` is valid from edge `2+DEBOUNCE_CYCLES` to edge `3+DEBOUNCE_CYCLES`.
- `direction` is high for exactly one cycle per accepted move.
- Moves emitted back to back from the buffer are separated by `LOCKOUT_CYCLES` zero cycles.
- `busy` is registered with the FSM state: it rises in the same cycle `direction` is non-zero and falls on the first IDLE cycle.
- A raw glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never changes `d`.
- A button held through reset deassertion is reported as a press after the normal debounce latency, because `d` resets to 0.
- **Reset mid-operation:**
  - It aborts EMIT and LOCKOUT.
  - The pending entry is lost.
  - `direction` goes to 0 asynchronously.

## Test plan
Benches use `DEBOUNCE_CYCLES=4` and `LOCKOUT_CYCLES=8`.
- **Single press:** `btn_up` rises and is held 20 cycles. `direction = 0100` for exactly one cycle, valid after edge 6 counted from the first sampling edge 0. `busy` is high for 9 cycles, then 0. Releasing the button produces no pulse.
- **Bounce rejection:** `btn_left` toggles 1,0,1,0 every 2 cycles, then stays 1. Exactly one `1000` pulse appears, 6 edges after the final stable sample.
- **Simultaneous press:** `btn_right` and `btn_down` rise on the same cycle and are held. `direction` stays `0000` and `busy` stays 0.
- **Buffered press:** press right; during LOCKOUT press down, then up.
  - Output: `0001`, then 8 zero cycles, then `0100` (the latest press wins; down is dropped).
  - After that, 8 more zero cycles, then IDLE.
- **Reset mid-lockout:** emit right, press left during LOCKOUT, then pulse `rst` low.
  - Outputs go to 0 immediately and no `1000` pulse follows.
  - A held `btn_left` re-emits `1000` after the debounce latency.
- **Held across reset:** `btn_down` is held while `rst` is deasserted. `direction = 0010` is valid after edge 6.

Source files
------------

// File: rtl/direction_input.sv
// Button conditioner for the 2048 game: synchronizes and debounces the four raw
// buttons and turns each clean press into one registered one-hot direction pulse.
module direction_input #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LOCKOUT_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] direction,
    output logic       busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    // Bit order matches the one-hot output code: right, down, up, left.
    logic [3:0] btn_raw;
    assign btn_raw = {btn_left, btn_up, btn_down, btn_right};

    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0]      stable_q, stable_d;
    logic [3:0]      stable_dly_q, stable_dly_d;
    logic [DB_W-1:0] cnt_q [4];
    logic [DB_W-1:0] cnt_d [4];

    logic [3:0]      press;
    logic            cand_valid;

    state_t          state_q, state_d;
    logic [LK_W-1:0] lock_q, lock_d;
    logic [3:0]      dir_q, dir_d;
    logic [3:0]      pend_code_q, pend_code_d;
    logic            pend_valid_q, pend_valid_d;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
        stable_d     = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Simultaneous presses are ambiguous, so only a lone press is a candidate.
    assign press      = stable_q & ~stable_dly_q;
    assign cand_valid = $onehot(press);

    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q;
        dir_d        = 4'b0000;
        pend_code_d  = pend_code_q;
        pend_valid_d = pend_valid_q;
        case (state_q)
            IDLE: begin
                if (cand_valid) begin
                    state_d = EMIT;
                    dir_d   = press;
                end
            end
            EMIT: begin
                state_d = LOCKOUT;
                lock_d  = '0;
            end
            LOCKOUT: begin
                if (lock_q == LK_LAST) begin
                    lock_d = '0;
                    if (pend_valid_q) begin
                        state_d      = EMIT;
                        dir_d        = pend_code_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Written after the consume above so a press on the consume cycle survives.
        if (cand_valid && state_q != IDLE) begin
            pend_code_d  = press;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            state_q      <= IDLE;
            lock_q       <= '0;
            dir_q        <= '0;
            pend_code_q  <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q      <= state_d;
            lock_q       <= lock_d;
            dir_q        <= dir_d;
            pend_code_q  <= pend_code_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign direction = dir_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_direction_input.sv
// Scoreboard bench for direction_input: stimulus queues expected moves with their
// emission edge, a negedge monitor pops and compares whenever a move appears.
module tb_direction_input;

    logic       clk;
    logic       rst;
    logic       btn_right;
    logic       btn_left;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] direction;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;
    int k;

    typedef struct {
        logic [3:0] code;
        int         at_edge;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    direction_input #(
        .DEBOUNCE_CYCLES(4),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_right(btn_right),
        .btn_left (btn_left),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .direction(direction),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    // Bit order: right, down, up, left -- the same as the direction code.
    task automatic applyStimulus(input logic [3:0] b);
        btn_right = b[0];
        btn_down  = b[1];
        btn_up    = b[2];
        btn_left  = b[3];
    endtask

    task automatic expect_move(input logic [3:0] code, input int at_edge);
        exp_t e;
        e.code    = code;
        e.at_edge = at_edge;
        exp_q.push_back(e);
    endtask

    task automatic wait_edge(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    task automatic drain_check(input string name);
        checkOutput(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && direction !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", {28'd0, direction}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("move_code", {28'd0, direction}, {28'd0, mon_e.code});
                checkOutput("move_edge", edge_cnt, mon_e.at_edge);
            end
        end
    end

    initial begin
        #100000;
        miscompares++;
        $display("[TB] FAIL watchdog: time limit reached at edge %0d", edge_cnt);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        rst = 1'b0;
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);
        checkOutput("reset_direction", {28'd0, direction}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single press of up, held then released.
        k = edge_cnt;
        applyStimulus(4'b0100);
        expect_move(4'b0100, k + 7);
        wait_edge(k + 6);
        checkOutput("up_busy_before", {31'd0, busy}, 32'd0);
        wait_edge(k + 7);
        checkOutput("up_busy_emit", {31'd0, busy}, 32'd1);
        wait_edge(k + 8);
        checkOutput("up_dir_cleared", {28'd0, direction}, 32'd0);
        wait_edge(k + 15);
        checkOutput("up_busy_last_lock", {31'd0, busy}, 32'd1);
        wait_edge(k + 16);
        checkOutput("up_busy_idle", {31'd0, busy}, 32'd0);
        wait_edge(k + 20);
        applyStimulus(4'b0000);
        wait_edge(k + 40);
        drain_check("up_pending");

        // Bouncing left: two short glitches, then a stable press.
        k = edge_cnt;
        applyStimulus(4'b1000);
        wait_edge(k + 2); applyStimulus(4'b0000);
        wait_edge(k + 4); applyStimulus(4'b1000);
        wait_edge(k + 6); applyStimulus(4'b0000);
        wait_edge(k + 8); applyStimulus(4'b1000);
        expect_move(4'b1000, k + 15);
        wait_edge(k + 14);
        checkOutput("bounce_busy_before", {31'd0, busy}, 32'd0);
        wait_edge(k + 15);
        checkOutput("bounce_busy_emit", {31'd0, busy}, 32'd1);
        wait_edge(k + 30);
        applyStimulus(4'b0000);
        wait_edge(k + 50);
        drain_check("bounce_pending");

        // Right and down together are ambiguous.
        k = edge_cnt;
        applyStimulus(4'b0011);
        for (int i = 1; i <= 14; i++) begin
            wait_edge(k + i);
            checkOutput("simul_busy", {31'd0, busy}, 32'd0);
        end
        wait_edge(k + 20);
        applyStimulus(4'b0000);
        wait_edge(k + 40);
        drain_check("simul_pending");

        // Right, then down and up during lockout: up replaces down.
        k = edge_cnt;
        applyStimulus(4'b0001);
        expect_move(4'b0001, k + 7);
        wait_edge(k + 5); applyStimulus(4'b0011);
        wait_edge(k + 7); applyStimulus(4'b0111);
        expect_move(4'b0100, k + 16);
        wait_edge(k + 16);
        checkOutput("buf_busy_second", {31'd0, busy}, 32'd1);
        wait_edge(k + 24);
        checkOutput("buf_busy_last_lock", {31'd0, busy}, 32'd1);
        wait_edge(k + 25);
        checkOutput("buf_busy_idle", {31'd0, busy}, 32'd0);
        wait_edge(k + 30);
        applyStimulus(4'b0000);
        wait_edge(k + 50);
        drain_check("buf_pending");

        // Reset during lockout drops the buffered left press.
        k = edge_cnt;
        applyStimulus(4'b0001);
        expect_move(4'b0001, k + 7);
        wait_edge(k + 5); applyStimulus(4'b1001);
        wait_edge(k + 13);
        checkOutput("rst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        applyStimulus(4'b1000);
        #1;
        checkOutput("rst_async_dir", {28'd0, direction}, 32'd0);
        checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
        wait_edge(k + 14);
        rst = 1'b1;
        expect_move(4'b1000, k + 21);
        wait_edge(k + 20);
        checkOutput("rst_no_stale", {31'd0, busy}, 32'd0);
        wait_edge(k + 30);
        applyStimulus(4'b0000);
        wait_edge(k + 50);
        drain_check("rst_pending");

        // Down held while reset is released.
        k = edge_cnt;
        rst = 1'b0;
        applyStimulus(4'b0010);
        wait_edge(k + 3);
        checkOutput("held_rst_dir", {28'd0, direction}, 32'd0);
        checkOutput("held_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        k = edge_cnt;
        expect_move(4'b0010, k + 7);
        wait_edge(k + 7);
        checkOutput("held_busy_emit", {31'd0, busy}, 32'd1);
        wait_edge(k + 20);
        applyStimulus(4'b0000);
        wait_edge(k + 40);
        drain_check("held_pending");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
